// File: rtl/rrs_exec_core_if.sv
`default_nettype none
// ============================================================================
// Module   : rrs_exec_core_if
// Brief    : Bundles the register-status table, CDB and arithmetic-unit
//            signals of rrs_exec_core into one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface rrs_exec_core_if #(
  parameter int WORD_SIZE = 32,
  parameter int UNIT_SIZE = 8,
  parameter int NUM_REGS  = 64
);
  localparam int IDX_W = $clog2(NUM_REGS);

  // Table access
  logic        [IDX_W-1:0]     reg_sel;
  logic                        wr_en;
  logic        [UNIT_SIZE-1:0] wr_tag;
  logic signed [WORD_SIZE-1:0] wr_value;
  logic        [UNIT_SIZE-1:0] rd_tag;
  logic signed [WORD_SIZE-1:0] rd_value;

  // Common data bus
  logic                        cdb_valid;
  logic        [UNIT_SIZE-1:0] cdb_tag;
  logic signed [WORD_SIZE-1:0] cdb_value;

  // Arithmetic units
  logic signed [WORD_SIZE-1:0] add_a;
  logic signed [WORD_SIZE-1:0] add_b;
  logic signed [WORD_SIZE-1:0] add_y;
  logic signed [WORD_SIZE-1:0] mul_a;
  logic signed [WORD_SIZE-1:0] mul_b;
  logic signed [WORD_SIZE-1:0] mul_y;

  // Front end that issues renames, broadcasts and operands
  modport master (
    output reg_sel, wr_en, wr_tag, wr_value,
    output cdb_valid, cdb_tag, cdb_value,
    output add_a, add_b, mul_a, mul_b,
    input  rd_tag, rd_value, add_y, mul_y
  );

  // The table / execution core itself
  modport slave (
    input  reg_sel, wr_en, wr_tag, wr_value,
    input  cdb_valid, cdb_tag, cdb_value,
    input  add_a, add_b, mul_a, mul_b,
    output rd_tag, rd_value, add_y, mul_y
  );
endinterface
`default_nettype wire

// File: rtl/rrs_exec_core.sv
`default_nettype none
// ============================================================================
// Module   : rrs_exec_core
// Brief    : Register-result-status table (tag or committed value per
//            architectural register) with CDB capture, plus combinational
//            32-bit add and multiply units.
// Revision : 1.0 - initial release
// ============================================================================
module rrs_exec_core #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   UNIT_SIZE = 8,
  parameter int                   NUM_REGS  = 64,
  parameter logic [UNIT_SIZE-1:0] READY_TAG = 8'h7F
) (
  input  wire logic     clk,
  input  wire logic     rst,
  rrs_exec_core_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic        [UNIT_SIZE-1:0] tag_q   [NUM_REGS];
  logic signed [WORD_SIZE-1:0] value_q [NUM_REGS];
  logic        [NUM_REGS-1:0]  cdb_hit;
  logic        [NUM_REGS-1:0]  wr_hit;
  logic                        wr_ready;

  // Per-entry strobes; a READY_TAG broadcast must not hit ready entries
  always_comb begin
    cdb_hit  = '0;
    wr_hit   = '0;
    wr_ready = (bus.wr_tag == READY_TAG);
    for (int i = 0; i < NUM_REGS; i++) begin
      cdb_hit[i] = bus.cdb_valid && (bus.cdb_tag != READY_TAG) &&
                   (tag_q[i] == bus.cdb_tag);
      wr_hit[i]  = bus.wr_en && (bus.reg_sel == IDX_W'(i));
    end
  end

  // Table update: CDB capture first, then the rename/immediate write on top.
  // A non-ready rename keeps whatever value the CDB just delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i]   <= READY_TAG;
        value_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          tag_q[i] <= bus.wr_tag;
        end else if (cdb_hit[i]) begin
          tag_q[i] <= READY_TAG;
        end

        if (wr_hit[i] && wr_ready) begin
          value_q[i] <= bus.wr_value;
        end else if (cdb_hit[i]) begin
          value_q[i] <= bus.cdb_value;
        end
      end
    end
  end

  // Read port: registered state only, no same-cycle bypass
  assign bus.rd_tag   = tag_q[bus.reg_sel];
  assign bus.rd_value = value_q[bus.reg_sel];

  // Execution units: wrap-around add, low half of signed product
  assign bus.add_y = bus.add_a + bus.add_b;
  assign bus.mul_y = bus.mul_a * bus.mul_b;

endmodule
`default_nettype wire

// File: tb/tb_rrs_exec_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rrs_exec_core
// Brief    : Scoreboard bench for rrs_exec_core with a behavioural table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rrs_exec_core;
  localparam logic [7:0] RDY = 8'h7F;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rrs_exec_core_if #(.WORD_SIZE(32), .UNIT_SIZE(8), .NUM_REGS(64)) bus ();

  rrs_exec_core #(
    .WORD_SIZE(32), .UNIT_SIZE(8), .NUM_REGS(64), .READY_TAG(8'h7F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] val;
    logic [31:0] add;
    logic [31:0] mul;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference table: what each architectural register holds
  logic [7:0]  m_tag [64];
  logic [31:0] m_val [64];

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_tag[i] = RDY;
      m_val[i] = 32'd0;
    end
  endfunction

  function automatic logic [31:0] ref_add(logic [31:0] a, logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return s[31:0];
  endfunction

  function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic void push_expect(int sel, logic [31:0] aa, logic [31:0] ab,
                                      logic [31:0] ma, logic [31:0] mb);
    exp_t e;
    e.tag = m_tag[sel];
    e.val = m_val[sel];
    e.add = ref_add(aa, ab);
    e.mul = ref_mul(ma, mb);
    sb.push_back(e);
  endfunction

  task automatic set_inputs(int sel, logic wen, logic [7:0] wtag, logic [31:0] wval,
                            logic cv, logic [7:0] ctag, logic [31:0] cval,
                            logic [31:0] aa, logic [31:0] ab,
                            logic [31:0] ma, logic [31:0] mb);
    bus.reg_sel   = 6'(sel);
    bus.wr_en     = wen;
    bus.wr_tag    = wtag;
    bus.wr_value  = wval;
    bus.cdb_valid = cv;
    bus.cdb_tag   = ctag;
    bus.cdb_value = cval;
    bus.add_a     = aa;
    bus.add_b     = ab;
    bus.mul_a     = ma;
    bus.mul_b     = mb;
  endtask

  // One cycle: apply inputs, expect pre-edge state, then retire the strobes
  task automatic drive(int sel, logic wen, logic [7:0] wtag, logic [31:0] wval,
                       logic cv, logic [7:0] ctag, logic [31:0] cval,
                       logic [31:0] aa, logic [31:0] ab,
                       logic [31:0] ma, logic [31:0] mb);
    set_inputs(sel, wen, wtag, wval, cv, ctag, cval, aa, ab, ma, mb);
    push_expect(sel, aa, ab, ma, mb);
    @(posedge clk);
    if (!rst) begin
      if (cv && ctag != RDY) begin
        for (int i = 0; i < 64; i++) begin
          if (m_tag[i] == ctag) begin
            m_tag[i] = RDY;
            m_val[i] = cval;
          end
        end
      end
      if (wen) begin
        m_tag[sel] = wtag;
        if (wtag == RDY) m_val[sel] = wval;
      end
    end
    #1;
  endtask

  task automatic rd(int sel);
    drive(sel, 1'b0, 8'h00, 32'd0, 1'b0, 8'h00, 32'd0,
          $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic wr(int sel, logic [7:0] t, logic [31:0] v);
    drive(sel, 1'b1, t, v, 1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic cdb(int sel, logic [7:0] t, logic [31:0] v);
    drive(sel, 1'b0, 8'h00, 32'd0, 1'b1, t, v, 32'd1, 32'd2, 32'd3, 32'd4);
  endtask

  // Asynchronous reset mid-cycle with strobes asserted; reads checked before any edge
  task automatic reset_pulse();
    set_inputs(0, 1'b1, 8'h23, 32'h1111_1111, 1'b1, 8'h41, 32'h2222_2222,
               32'd5, 32'd6, 32'd7, 32'd8);
    #1 rst = 1'b1;
    model_reset();
    push_expect(0, 32'd5, 32'd6, 32'd7, 32'd8);
    @(posedge clk);
    #1;
    drive(37, 1'b1, 8'h23, 32'h3, 1'b1, 8'h23, 32'h4, 32'd1, 32'd1, 32'd2, 32'd2);
    drive(63, 1'b1, 8'h81, 32'h5, 1'b1, 8'h81, 32'h6, 32'd9, 32'd9, 32'd3, 32'd3);
    rst = 1'b0;
  endtask

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: outputs are present every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("rd_tag",   32'(bus.rd_tag), 32'(e.tag));
      cmp("rd_value", bus.rd_value,    e.val);
      cmp("add_y",    bus.add_y,       e.add);
      cmp("mul_y",    bus.mul_y,       e.mul);
    end
  end

  localparam logic [7:0] TAGS [6] = '{8'h23, 8'h41, 8'h81, 8'h7F, 8'h05, 8'hE3};

  initial begin
    model_reset();
    set_inputs(0, 1'b0, 8'h00, 32'd0, 1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Dirty a few entries, then reset and read back 0/37/63
    wr(0, 8'h23, 32'd0);
    wr(37, 8'h7F, 32'h1234_5678);
    wr(63, 8'h40, 32'd0);
    reset_pulse();
    rd(0);

    // Rename then broadcast, with arithmetic corner vectors on the side
    drive(5, 1'b1, 8'h23, 32'd555, 1'b0, 8'h00, 32'd0,
          32'h7FFF_FFFF, 32'd1, 32'd3, -32'sd4);
    drive(5, 1'b0, 8'h00, 32'd0, 1'b0, 8'h00, 32'd0,
          -32'sd5, 32'd3, 32'd10000, 32'd10000);
    cdb(5, 8'h23, 32'd1234);
    rd(5);

    // Multi-match broadcast
    wr(1, 8'h81, 32'd0);
    wr(2, 8'h81, 32'd0);
    wr(3, 8'h81, 32'd0);
    wr(4, 8'h40, 32'd0);
    cdb(1, 8'h81, -32'sd7);
    for (int r = 1; r <= 4; r++) rd(r);

    // Immediate write
    wr(10, 8'h7F, 32'hDEAD_BEEF);
    rd(10);

    // Ready-tag broadcast is ignored
    cdb(10, 8'h7F, 32'h0BAD_0BAD);
    rd(10);

    // Simultaneous CDB and rename of a matching register
    wr(7, 8'h41, 32'd0);
    wr(8, 8'h41, 32'd0);
    drive(7, 1'b1, 8'h22, 32'd0, 1'b1, 8'h41, 32'd99, 32'd0, 32'd0, 32'd0, 32'd0);
    rd(7);
    rd(8);

    // Randomised traffic over a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7),
            1'($urandom_range(0, 1)), TAGS[$urandom_range(0, 5)], $urandom,
            1'($urandom_range(0, 2) == 0), TAGS[$urandom_range(0, 5)], $urandom,
            $urandom, $urandom, $urandom, $urandom);
    end

    reset_pulse();
    for (int r = 0; r < 8; r++) rd(r);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
